mpc_2x2_ctrl: RTL and testbench

// - Pad/bus multiplexer for a 2x2 array of four user macros (index 0..3) that share one set of chip IOs.
// - A 4-bit configuration word selects which macro owns the north/east/west pads and the Wishbone slave port.
// - Sits between the pad ring / Wishbone master and the four macro instances.
// - Purely routing plus one configuration register.

---
 rtl/mpc_2x2_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_mpc_2x2_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mpc_2x2_ctrl.sv
// Pad and Wishbone multiplexer for a 2x2 array of user macros sharing one set of chip IOs.
// A registered 4-bit configuration picks the owner of the north/east/west pads and the bus port.
module mpc_2x2_ctrl #(
  parameter int unsigned NW = 10,
  parameter int unsigned EW = 14,
  parameter int unsigned WW = 14
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [3:0]    configuration,

  input  logic [NW-1:0] IO_north_i,
  output logic [NW-1:0] IO_north_o,
  output logic [NW-1:0] IO_north_oe,
  input  logic [EW-1:0] IO_east_i,
  output logic [EW-1:0] IO_east_o,
  output logic [EW-1:0] IO_east_oe,
  input  logic [WW-1:0] IO_west_i,
  output logic [WW-1:0] IO_west_o,
  output logic [WW-1:0] IO_west_oe,

  input  logic [NW-1:0] north_o_0,
  input  logic [NW-1:0] north_oe_0,
  input  logic [EW-1:0] east_o_0,
  input  logic [EW-1:0] east_oe_0,
  input  logic [WW-1:0] west_o_0,
  input  logic [WW-1:0] west_oe_0,
  output logic [NW-1:0] north_i_0,
  output logic [EW-1:0] east_i_0,
  output logic [WW-1:0] west_i_0,

  input  logic [NW-1:0] north_o_1,
  input  logic [NW-1:0] north_oe_1,
  input  logic [EW-1:0] east_o_1,
  input  logic [EW-1:0] east_oe_1,
  input  logic [WW-1:0] west_o_1,
  input  logic [WW-1:0] west_oe_1,
  output logic [NW-1:0] north_i_1,
  output logic [EW-1:0] east_i_1,
  output logic [WW-1:0] west_i_1,

  input  logic [NW-1:0] north_o_2,
  input  logic [NW-1:0] north_oe_2,
  input  logic [EW-1:0] east_o_2,
  input  logic [EW-1:0] east_oe_2,
  input  logic [WW-1:0] west_o_2,
  input  logic [WW-1:0] west_oe_2,
  output logic [NW-1:0] north_i_2,
  output logic [EW-1:0] east_i_2,
  output logic [WW-1:0] west_i_2,

  input  logic [NW-1:0] north_o_3,
  input  logic [NW-1:0] north_oe_3,
  input  logic [EW-1:0] east_o_3,
  input  logic [EW-1:0] east_oe_3,
  input  logic [WW-1:0] west_o_3,
  input  logic [WW-1:0] west_oe_3,
  output logic [NW-1:0] north_i_3,
  output logic [EW-1:0] east_i_3,
  output logic [WW-1:0] west_i_3,

  input  logic          wbs_stb_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_dat_i,
  input  logic [31:0]   wbs_adr_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,

  output logic          wb_clk_i_0,
  output logic          wb_rst_i_0,
  output logic          wbs_stb_i_0,
  output logic          wbs_cyc_i_0,
  output logic          wbs_we_i_0,
  output logic [3:0]    wbs_sel_i_0,
  output logic [31:0]   wbs_dat_i_0,
  output logic [31:0]   wbs_adr_i_0,
  input  logic          wbs_ack_o_0,
  input  logic [31:0]   wbs_dat_o_0,

  output logic          wb_clk_i_1,
  output logic          wb_rst_i_1,
  output logic          wbs_stb_i_1,
  output logic          wbs_cyc_i_1,
  output logic          wbs_we_i_1,
  output logic [3:0]    wbs_sel_i_1,
  output logic [31:0]   wbs_dat_i_1,
  output logic [31:0]   wbs_adr_i_1,
  input  logic          wbs_ack_o_1,
  input  logic [31:0]   wbs_dat_o_1,

  output logic          wb_clk_i_2,
  output logic          wb_rst_i_2,
  output logic          wbs_stb_i_2,
  output logic          wbs_cyc_i_2,
  output logic          wbs_we_i_2,
  output logic [3:0]    wbs_sel_i_2,
  output logic [31:0]   wbs_dat_i_2,
  output logic [31:0]   wbs_adr_i_2,
  input  logic          wbs_ack_o_2,
  input  logic [31:0]   wbs_dat_o_2,

  output logic          wb_clk_i_3,
  output logic          wb_rst_i_3,
  output logic          wbs_stb_i_3,
  output logic          wbs_cyc_i_3,
  output logic          wbs_we_i_3,
  output logic [3:0]    wbs_sel_i_3,
  output logic [31:0]   wbs_dat_i_3,
  output logic [31:0]   wbs_adr_i_3,
  input  logic          wbs_ack_o_3,
  input  logic [31:0]   wbs_dat_o_3
);

  logic [3:0] cfg_q;
  logic [1:0] sel_s;
  logic [1:0] sel_w;
  logic       pads_off;

  // Selection is frozen while a bus cycle is open so ownership never moves mid-transfer.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cfg_q <= 4'd0;
    end else if (!wbs_cyc_i) begin
      cfg_q <= configuration;
    end
  end

  assign sel_s    = cfg_q[1:0];
  assign sel_w    = cfg_q[2] ? (sel_s ^ 2'd1) : sel_s;
  assign pads_off = cfg_q[3] | wb_rst_i;

  logic [3:0][NW-1:0] n_o, n_oe, n_i;
  logic [3:0][EW-1:0] e_o, e_oe, e_i;
  logic [3:0][WW-1:0] w_o, w_oe, w_i;
  logic [3:0]         ack_v;
  logic [3:0][31:0]   dat_v;
  logic [3:0]         own;

  assign n_o   = {north_o_3, north_o_2, north_o_1, north_o_0};
  assign n_oe  = {north_oe_3, north_oe_2, north_oe_1, north_oe_0};
  assign e_o   = {east_o_3, east_o_2, east_o_1, east_o_0};
  assign e_oe  = {east_oe_3, east_oe_2, east_oe_1, east_oe_0};
  assign w_o   = {west_o_3, west_o_2, west_o_1, west_o_0};
  assign w_oe  = {west_oe_3, west_oe_2, west_oe_1, west_oe_0};
  assign ack_v = {wbs_ack_o_3, wbs_ack_o_2, wbs_ack_o_1, wbs_ack_o_0};
  assign dat_v = {wbs_dat_o_3, wbs_dat_o_2, wbs_dat_o_1, wbs_dat_o_0};

  always_comb begin
    IO_north_o  = pads_off ? '0 : n_o[sel_s];
    IO_north_oe = pads_off ? '0 : n_oe[sel_s];
    IO_east_o   = pads_off ? '0 : e_o[sel_s];
    IO_east_oe  = pads_off ? '0 : e_oe[sel_s];
    IO_west_o   = pads_off ? '0 : w_o[sel_w];
    IO_west_oe  = pads_off ? '0 : w_oe[sel_w];
  end

  // Unselected macros see quiet pads rather than a copy of the real inputs.
  always_comb begin
    n_i          = '0;
    e_i          = '0;
    w_i          = '0;
    n_i[sel_s]   = IO_north_i;
    e_i[sel_s]   = IO_east_i;
    w_i[sel_w]   = IO_west_i;
  end

  assign north_i_0 = n_i[0];
  assign north_i_1 = n_i[1];
  assign north_i_2 = n_i[2];
  assign north_i_3 = n_i[3];
  assign east_i_0  = e_i[0];
  assign east_i_1  = e_i[1];
  assign east_i_2  = e_i[2];
  assign east_i_3  = e_i[3];
  assign west_i_0  = w_i[0];
  assign west_i_1  = w_i[1];
  assign west_i_2  = w_i[2];
  assign west_i_3  = w_i[3];

  always_comb begin
    own        = '0;
    own[sel_s] = ~wb_rst_i;
  end

  assign wbs_stb_i_0 = wbs_stb_i & own[0];
  assign wbs_stb_i_1 = wbs_stb_i & own[1];
  assign wbs_stb_i_2 = wbs_stb_i & own[2];
  assign wbs_stb_i_3 = wbs_stb_i & own[3];
  assign wbs_cyc_i_0 = wbs_cyc_i & own[0];
  assign wbs_cyc_i_1 = wbs_cyc_i & own[1];
  assign wbs_cyc_i_2 = wbs_cyc_i & own[2];
  assign wbs_cyc_i_3 = wbs_cyc_i & own[3];

  assign wb_clk_i_0 = wb_clk_i;
  assign wb_clk_i_1 = wb_clk_i;
  assign wb_clk_i_2 = wb_clk_i;
  assign wb_clk_i_3 = wb_clk_i;
  assign wb_rst_i_0 = wb_rst_i;
  assign wb_rst_i_1 = wb_rst_i;
  assign wb_rst_i_2 = wb_rst_i;
  assign wb_rst_i_3 = wb_rst_i;

  assign wbs_we_i_0  = wbs_we_i;
  assign wbs_we_i_1  = wbs_we_i;
  assign wbs_we_i_2  = wbs_we_i;
  assign wbs_we_i_3  = wbs_we_i;
  assign wbs_sel_i_0 = wbs_sel_i;
  assign wbs_sel_i_1 = wbs_sel_i;
  assign wbs_sel_i_2 = wbs_sel_i;
  assign wbs_sel_i_3 = wbs_sel_i;
  assign wbs_dat_i_0 = wbs_dat_i;
  assign wbs_dat_i_1 = wbs_dat_i;
  assign wbs_dat_i_2 = wbs_dat_i;
  assign wbs_dat_i_3 = wbs_dat_i;
  assign wbs_adr_i_0 = wbs_adr_i;
  assign wbs_adr_i_1 = wbs_adr_i;
  assign wbs_adr_i_2 = wbs_adr_i;
  assign wbs_adr_i_3 = wbs_adr_i;

  assign wbs_ack_o = wb_rst_i ? 1'b0 : ack_v[sel_s];
  assign wbs_dat_o = wb_rst_i ? 32'd0 : dat_v[sel_s];

endmodule

// File: tb/tb_mpc_2x2_ctrl.sv
// Scoreboard bench for mpc_2x2_ctrl: expected routing is queued when stimulus is driven
// and compared against the DUT one half-cycle after the following clock edge.
module tb_mpc_2x2_ctrl;
  localparam int unsigned NW = 10;
  localparam int unsigned EW = 14;
  localparam int unsigned WW = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [3:0]    configuration;
  logic [NW-1:0] io_n_i;
  logic [EW-1:0] io_e_i;
  logic [WW-1:0] io_w_i;
  logic [NW-1:0] io_n_o, io_n_oe;
  logic [EW-1:0] io_e_o, io_e_oe;
  logic [WW-1:0] io_w_o, io_w_oe;

  logic [3:0][NW-1:0] n_o_v, n_oe_v, n_i_v;
  logic [3:0][EW-1:0] e_o_v, e_oe_v, e_i_v;
  logic [3:0][WW-1:0] w_o_v, w_oe_v, w_i_v;

  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat, adr;
  logic        ack;
  logic [31:0] rdat;

  logic [3:0]       clk_v, rst_v, stb_v, cyc_v, we_v, ack_v;
  logic [3:0][3:0]  sel_v;
  logic [3:0][31:0] dat_i_v, adr_i_v, dat_o_v;

  mpc_2x2_ctrl #(.NW(NW), .EW(EW), .WW(WW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .configuration(configuration),
    .IO_north_i(io_n_i), .IO_north_o(io_n_o), .IO_north_oe(io_n_oe),
    .IO_east_i(io_e_i), .IO_east_o(io_e_o), .IO_east_oe(io_e_oe),
    .IO_west_i(io_w_i), .IO_west_o(io_w_o), .IO_west_oe(io_w_oe),
    .north_o_0(n_o_v[0]), .north_oe_0(n_oe_v[0]), .east_o_0(e_o_v[0]), .east_oe_0(e_oe_v[0]),
    .west_o_0(w_o_v[0]), .west_oe_0(w_oe_v[0]),
    .north_i_0(n_i_v[0]), .east_i_0(e_i_v[0]), .west_i_0(w_i_v[0]),
    .north_o_1(n_o_v[1]), .north_oe_1(n_oe_v[1]), .east_o_1(e_o_v[1]), .east_oe_1(e_oe_v[1]),
    .west_o_1(w_o_v[1]), .west_oe_1(w_oe_v[1]),
    .north_i_1(n_i_v[1]), .east_i_1(e_i_v[1]), .west_i_1(w_i_v[1]),
    .north_o_2(n_o_v[2]), .north_oe_2(n_oe_v[2]), .east_o_2(e_o_v[2]), .east_oe_2(e_oe_v[2]),
    .west_o_2(w_o_v[2]), .west_oe_2(w_oe_v[2]),
    .north_i_2(n_i_v[2]), .east_i_2(e_i_v[2]), .west_i_2(w_i_v[2]),
    .north_o_3(n_o_v[3]), .north_oe_3(n_oe_v[3]), .east_o_3(e_o_v[3]), .east_oe_3(e_oe_v[3]),
    .west_o_3(w_o_v[3]), .west_oe_3(w_oe_v[3]),
    .north_i_3(n_i_v[3]), .east_i_3(e_i_v[3]), .west_i_3(w_i_v[3]),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(dat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .wb_clk_i_0(clk_v[0]), .wb_rst_i_0(rst_v[0]), .wbs_stb_i_0(stb_v[0]), .wbs_cyc_i_0(cyc_v[0]),
    .wbs_we_i_0(we_v[0]), .wbs_sel_i_0(sel_v[0]), .wbs_dat_i_0(dat_i_v[0]),
    .wbs_adr_i_0(adr_i_v[0]), .wbs_ack_o_0(ack_v[0]), .wbs_dat_o_0(dat_o_v[0]),
    .wb_clk_i_1(clk_v[1]), .wb_rst_i_1(rst_v[1]), .wbs_stb_i_1(stb_v[1]), .wbs_cyc_i_1(cyc_v[1]),
    .wbs_we_i_1(we_v[1]), .wbs_sel_i_1(sel_v[1]), .wbs_dat_i_1(dat_i_v[1]),
    .wbs_adr_i_1(adr_i_v[1]), .wbs_ack_o_1(ack_v[1]), .wbs_dat_o_1(dat_o_v[1]),
    .wb_clk_i_2(clk_v[2]), .wb_rst_i_2(rst_v[2]), .wbs_stb_i_2(stb_v[2]), .wbs_cyc_i_2(cyc_v[2]),
    .wbs_we_i_2(we_v[2]), .wbs_sel_i_2(sel_v[2]), .wbs_dat_i_2(dat_i_v[2]),
    .wbs_adr_i_2(adr_i_v[2]), .wbs_ack_o_2(ack_v[2]), .wbs_dat_o_2(dat_o_v[2]),
    .wb_clk_i_3(clk_v[3]), .wb_rst_i_3(rst_v[3]), .wbs_stb_i_3(stb_v[3]), .wbs_cyc_i_3(cyc_v[3]),
    .wbs_we_i_3(we_v[3]), .wbs_sel_i_3(sel_v[3]), .wbs_dat_i_3(dat_i_v[3]),
    .wbs_adr_i_3(adr_i_v[3]), .wbs_ack_o_3(ack_v[3]), .wbs_dat_o_3(dat_o_v[3])
  );

  typedef struct {
    int          id;
    logic [63:0] exp;
  } exp_t;

  exp_t  sb[$];
  int    n_checks = 0;
  int    n_fails  = 0;
  string phase    = "init";
  logic [3:0] model_cfg;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic string sig_name(input int id);
    string names[12] = '{"IO_north_o", "IO_north_oe", "IO_east_o", "IO_east_oe", "IO_west_o",
                         "IO_west_oe", "north_i", "east_i", "west_i", "stb", "cyc", "bcast"};
    if (id < 6) return names[id];
    if (id < 30) return $sformatf("%s_%0d", names[6 + (id - 6) / 4], (id - 6) % 4);
    if (id == 30) return "wbs_ack_o";
    if (id == 31) return "wbs_dat_o";
    return $sformatf("%s_%0d", (id < 36) ? "dat_i" : (id < 40) ? "adr_i" : (id < 44) ? "sel_i" :
                     (id < 48) ? "we_i" : "rst_i", id % 4);
  endfunction

  function automatic logic [63:0] obs_of(input int id);
    int k;
    k = id % 4;
    case (id)
      0:  return 64'(io_n_o);
      1:  return 64'(io_n_oe);
      2:  return 64'(io_e_o);
      3:  return 64'(io_e_oe);
      4:  return 64'(io_w_o);
      5:  return 64'(io_w_oe);
      30: return 64'(ack);
      31: return 64'(rdat);
      default: begin
        k = (id - 6) % 4;
        if (id < 10) return 64'(n_i_v[k]);
        if (id < 14) return 64'(e_i_v[k]);
        if (id < 18) return 64'(w_i_v[k]);
        if (id < 22) return 64'(stb_v[k]);
        if (id < 26) return 64'(cyc_v[k]);
        k = id % 4;
        if (id < 36) return 64'(dat_i_v[k]);
        if (id < 40) return 64'(adr_i_v[k]);
        if (id < 44) return 64'(sel_v[k]);
        if (id < 48) return 64'(we_v[k]);
        return 64'(rst_v[k]);
      end
    endcase
  endfunction

  task automatic push(input int id, input logic [63:0] exp);
    exp_t e;
    e.id  = id;
    e.exp = exp;
    sb.push_back(e);
  endtask

  // Expected view of every routed signal for a given registered config and reset level.
  task automatic push_expect(input logic [3:0] c, input logic r);
    logic [1:0] s, w;
    logic       off;
    s   = c[1:0];
    w   = c[2] ? (s ^ 2'd1) : s;
    off = c[3] | r;
    push(0, off ? 64'd0 : 64'(n_o_v[s]));
    push(1, off ? 64'd0 : 64'(n_oe_v[s]));
    push(2, off ? 64'd0 : 64'(e_o_v[s]));
    push(3, off ? 64'd0 : 64'(e_oe_v[s]));
    push(4, off ? 64'd0 : 64'(w_o_v[w]));
    push(5, off ? 64'd0 : 64'(w_oe_v[w]));
    for (int k = 0; k < 4; k++) begin
      push(6 + k,  (k == int'(s)) ? 64'(io_n_i) : 64'd0);
      push(10 + k, (k == int'(s)) ? 64'(io_e_i) : 64'd0);
      push(14 + k, (k == int'(w)) ? 64'(io_w_i) : 64'd0);
      push(18 + k, 64'(stb & (k == int'(s)) & ~r));
      push(22 + k, 64'(cyc & (k == int'(s)) & ~r));
      push(32 + k, 64'(dat));
      push(36 + k, 64'(adr));
      push(40 + k, 64'(sel));
      push(44 + k, 64'(we));
      push(48 + k, 64'(r));
    end
    push(30, r ? 64'd0 : 64'(ack_v[s]));
    push(31, r ? 64'd0 : 64'(dat_o_v[s]));
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq({phase, ":", sig_name(e.id)}, obs_of(e.id), e.exp);
    end
  endtask

  // Called at a negedge with all inputs already driven: predicts the state after the next
  // rising edge, then samples at the following negedge.
  task automatic step(input logic [3:0] cfg_in);
    configuration = cfg_in;
    if (rst) model_cfg = 4'd0;
    else if (!cyc) model_cfg = cfg_in;
    @(posedge clk);
    #1;
    push_expect(model_cfg, rst);
    @(negedge clk);
    drain();
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      n_o_v[k]   = NW'(10'h050 + k);
      n_oe_v[k]  = NW'(10'h0a0 + k);
      e_o_v[k]   = EW'(14'h1000 + k);
      e_oe_v[k]  = EW'(14'h2000 + k);
      w_o_v[k]   = WW'(14'h0300 + k);
      w_oe_v[k]  = WW'(14'h0c00 + k);
      dat_o_v[k] = 32'hd000_0000 + 32'(k);
    end
    ack_v = 4'b1111;
    rst = 1'b1; configuration = 4'd0;
    io_n_i = '0; io_e_i = '0; io_w_i = '0;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; sel = 4'h0; dat = 32'd0; adr = 32'd0;
    model_cfg = 4'd0;

    @(negedge clk);
    phase = "reset";
    step(4'd5);

    phase = "release";
    rst = 1'b0; stb = 1'b0; cyc = 1'b0; io_n_i = NW'(25);
    step(4'd0);

    phase = "sweep";
    io_n_i = '0; io_e_i = EW'(30);
    for (int i = 0; i < 16; i++) step(4'(i));

    phase = "split";
    io_e_i = '0; io_w_i = WW'(35);
    step(4'b0110);

    phase = "disable";
    io_w_i = '0; io_n_i = NW'(25);
    step(4'b1001);

    phase = "write";
    io_n_i = '0;
    step(4'd2);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; sel = 4'ha; dat = 32'd20; adr = 32'd30;
    ack_v = 4'b0100;
    step(4'd2);
    ack_v = 4'b1011;
    step(4'd2);

    phase = "hold";
    ack_v = 4'b0100;
    step(4'd1);
    step(4'd3);
    stb = 1'b0; cyc = 1'b0;
    step(4'd1);

    phase = "rst_mid";
    stb = 1'b1; cyc = 1'b1; ack_v = 4'b1111;
    step(4'd1);
    rst = 1'b1;
    step(4'd3);
    rst = 1'b0; stb = 1'b0; cyc = 1'b0;
    step(4'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
